// File: rtl/jt1943_prot_if.sv
// CPU bus front-end for the 1943 protection lookup: one write strobe per
// CPU access, latency wait-out, read holding register and Z80 WAIT.
module jt1943_prot_if #(
    parameter int LUT_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cpu_cs,
    input  logic       cpu_rd_n,
    input  logic       cpu_wr_n,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       cpu_wait_n,
    output logic       sec_cs,
    output logic       sec_wr_n,
    output logic [7:0] sec_din,
    input  logic [7:0] sec_dout,
    output logic [7:0] wr_cnt
);

    localparam int CW = $clog2(LUT_LAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cs_l_q, cs_l_d;
    logic           valid_q, valid_d;
    logic [7:0]     dout_q, dout_d;
    logic           wait_n_q, wait_n_d;
    logic           scs_q, scs_d;
    logic           swr_n_q, swr_n_d;
    logic [7:0]     sdin_q, sdin_d;
    logic [7:0]     wcnt_q, wcnt_d;

    logic act, wr, rd;

    assign act = cpu_cs & ~cs_l_q;
    assign wr  = act & ~cpu_wr_n;
    assign rd  = cpu_cs & ~cpu_rd_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_l_d  = cpu_cs;
        valid_d = valid_q;
        dout_d  = dout_q;
        scs_d   = scs_q;
        swr_n_d = swr_n_q;
        sdin_d  = sdin_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (wr) begin
                    sdin_d  = cpu_din;
                    scs_d   = 1'b1;
                    swr_n_d = 1'b0;
                    valid_d = 1'b0;
                    wcnt_d  = wcnt_q + 8'd1;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                scs_d   = 1'b0;
                swr_n_d = 1'b1;
                cnt_d   = CW'(LUT_LAT);
                state_d = SETTLE;
            end
            SETTLE: begin
                // a new key restarts the lookup; the old answer is never captured
                if (wr) begin
                    sdin_d  = cpu_din;
                    scs_d   = 1'b1;
                    swr_n_d = 1'b0;
                    valid_d = 1'b0;
                    wcnt_d  = wcnt_q + 8'd1;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        dout_d  = sec_dout;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // WAIT releases together with the capture, so data is ready when it rises
        wait_n_d = ~(rd & ~valid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cs_l_q   <= 1'b0;
            valid_q  <= 1'b1;
            dout_q   <= 8'h00;
            wait_n_q <= 1'b1;
            scs_q    <= 1'b0;
            swr_n_q  <= 1'b1;
            sdin_q   <= 8'h00;
            wcnt_q   <= 8'h00;
        end else if (cen) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cs_l_q   <= cs_l_d;
            valid_q  <= valid_d;
            dout_q   <= dout_d;
            wait_n_q <= wait_n_d;
            scs_q    <= scs_d;
            swr_n_q  <= swr_n_d;
            sdin_q   <= sdin_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign cpu_dout   = dout_q;
    assign cpu_wait_n = wait_n_q;
    assign sec_cs     = scs_q;
    assign sec_wr_n   = swr_n_q;
    assign sec_din    = sdin_q;
    assign wr_cnt     = wcnt_q;

endmodule

// File: tb/tb_jt1943_prot_if.sv
// Directed bench for jt1943_prot_if with a small registered lookup model.
module tb_jt1943_prot_if;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b1;
    logic       cpu_cs = 1'b0;
    logic       cpu_rd_n = 1'b1;
    logic       cpu_wr_n = 1'b1;
    logic [7:0] cpu_din = 8'h00;
    logic [7:0] cpu_dout;
    logic       cpu_wait_n;
    logic       sec_cs;
    logic       sec_wr_n;
    logic [7:0] sec_din;
    logic [7:0] sec_dout = 8'h00;
    logic [7:0] wr_cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    jt1943_prot_if #(.LUT_LAT(2)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .cpu_cs(cpu_cs), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n),
        .sec_cs(sec_cs), .sec_wr_n(sec_wr_n), .sec_din(sec_din),
        .sec_dout(sec_dout), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lut(input logic [7:0] k);
        case (k)
            8'h24:   return 8'h1D;
            8'h60:   return 8'hF7;
            8'h01:   return 8'hAC;
            8'h55:   return 8'h50;
            8'h3B:   return 8'hC4;
            8'hA5:   return 8'h5A;
            default: return ~k;
        endcase
    endfunction

    // lookup block: not reset, so a stale answer stays visible
    always @(posedge clk) begin
        if (cen && sec_cs && !sec_wr_n) begin
            sec_dout <= lut(sec_din);
            pulses   <= pulses + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cen = 1'b1;
        cpu_cs = 1'b0; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_din = 8'h00;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk("rst_dout", cpu_dout, 8'h00);
        chk("rst_wait", {7'd0, cpu_wait_n}, 8'h01);
        chk("rst_seccs", {7'd0, sec_cs}, 8'h00);
        chk("rst_secwr", {7'd0, sec_wr_n}, 8'h01);
        chk("rst_secdin", sec_din, 8'h00);
        chk("rst_wrcnt", wr_cnt, 8'h00);
    endtask

    task automatic test_write_read();
        int n;
        do_reset();
        cpu_cs = 1'b1; cpu_wr_n = 1'b0; cpu_din = 8'h24;
        tick();
        chk("t1_strobe_cs", {7'd0, sec_cs}, 8'h01);
        chk("t1_strobe_wr", {7'd0, sec_wr_n}, 8'h00);
        chk("t1_secdin", sec_din, 8'h24);
        chk("t1_wrcnt", wr_cnt, 8'h01);
        cpu_wr_n = 1'b1; cpu_rd_n = 1'b0;
        tick();
        chk("t1_strobe_end", {7'd0, sec_wr_n}, 8'h01);
        n = 0;
        while (!cpu_wait_n && n < 10) begin
            n++;
            tick();
        end
        chk("t1_wait_ticks", 8'(n), 8'd2);
        chk("t1_dout", cpu_dout, 8'h1D);
        cpu_cs = 1'b0; cpu_rd_n = 1'b1;
        tick();
    endtask

    task automatic test_rewrite();
        int p0;
        logic saw_old;
        do_reset();
        p0 = pulses;
        saw_old = 1'b0;
        cpu_cs = 1'b1; cpu_wr_n = 1'b0; cpu_din = 8'h60;
        tick();
        cpu_cs = 1'b0; cpu_wr_n = 1'b1;
        tick();
        tick();
        cpu_cs = 1'b1; cpu_wr_n = 1'b0; cpu_din = 8'h01;
        tick();
        if (cpu_dout == 8'hF7) saw_old = 1'b1;
        cpu_cs = 1'b0; cpu_wr_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_dout == 8'hF7) saw_old = 1'b1;
        end
        cpu_cs = 1'b1; cpu_rd_n = 1'b0;
        tick();
        chk("t2_pulses", 8'(pulses - p0), 8'd2);
        chk("t2_wrcnt", wr_cnt, 8'd2);
        chk("t2_no_old", {7'd0, saw_old}, 8'h00);
        chk("t2_dout", cpu_dout, 8'hAC);
        chk("t2_wait", {7'd0, cpu_wait_n}, 8'h01);
        cpu_cs = 1'b0; cpu_rd_n = 1'b1;
        tick();
    endtask

    task automatic test_read_after_reset();
        int p0;
        logic low;
        do_reset();
        p0 = pulses;
        low = 1'b0;
        cpu_cs = 1'b1; cpu_rd_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!cpu_wait_n) low = 1'b1;
        end
        chk("t3_wait_low", {7'd0, low}, 8'h00);
        chk("t3_dout", cpu_dout, 8'h00);
        chk("t3_pulses", 8'(pulses - p0), 8'd0);
        cpu_cs = 1'b0; cpu_rd_n = 1'b1;
        tick();
    endtask

    task automatic test_held_write();
        int p0;
        do_reset();
        p0 = pulses;
        cpu_cs = 1'b1; cpu_wr_n = 1'b0; cpu_din = 8'h55;
        for (int i = 0; i < 5; i++) tick();
        cpu_cs = 1'b0; cpu_wr_n = 1'b1;
        tick(); tick();
        chk("t4_pulses", 8'(pulses - p0), 8'd1);
        chk("t4_wrcnt", wr_cnt, 8'd1);
        cpu_cs = 1'b1; cpu_rd_n = 1'b0;
        tick();
        chk("t4_dout", cpu_dout, 8'h50);
        chk("t4_wait", {7'd0, cpu_wait_n}, 8'h01);
        cpu_cs = 1'b0; cpu_rd_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_settle();
        do_reset();
        cpu_cs = 1'b1; cpu_wr_n = 1'b0; cpu_din = 8'h3B;
        tick();
        cpu_wr_n = 1'b1; cpu_rd_n = 1'b0;
        tick();
        tick();
        chk("t5_wait_pre", {7'd0, cpu_wait_n}, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_wait", {7'd0, cpu_wait_n}, 8'h01);
        chk("t5_dout", cpu_dout, 8'h00);
        chk("t5_seccs", {7'd0, sec_cs}, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_no_capture", cpu_dout, 8'h00);
        chk("t5_wait_after", {7'd0, cpu_wait_n}, 8'h01);
        cpu_cs = 1'b0; cpu_rd_n = 1'b1;
        tick();
    endtask

    task automatic test_cen_and_wrap();
        do_reset();
        cpu_cs = 1'b1; cpu_wr_n = 1'b0; cpu_din = 8'hA5;
        tick();
        cpu_cs = 1'b0; cpu_wr_n = 1'b1;
        tick();
        cen = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_hold_dout", cpu_dout, 8'h00);
        cen = 1'b1;
        tick();
        chk("t6_not_yet", cpu_dout, 8'h00);
        tick();
        chk("t6_dout", cpu_dout, 8'h5A);
        for (int i = 0; i < 254; i++) begin
            cpu_cs = 1'b1; cpu_wr_n = 1'b0; cpu_din = 8'(i);
            tick();
            cpu_cs = 1'b0; cpu_wr_n = 1'b1;
            tick();
        end
        chk("t6_wrcnt_ff", wr_cnt, 8'hFF);
        cpu_cs = 1'b1; cpu_wr_n = 1'b0; cpu_din = 8'h77;
        tick();
        cpu_cs = 1'b0; cpu_wr_n = 1'b1;
        tick();
        chk("t6_wrcnt_wrap", wr_cnt, 8'h00);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rewrite();
        test_read_after_reset();
        test_held_write();
        test_reset_settle();
        test_cen_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
